// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side bus bundle for mem_arbiter: CPU port, loader port and
// the single-port RAM connection. The arbiter uses the slave view.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    logic [1:0]            cpu_cmd;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;

    logic [1:0]            ldr_cmd;
    logic [ADDR_WIDTH-1:0] ldr_addr;
    logic [DATA_WIDTH-1:0] ldr_wdata;
    logic [DATA_WIDTH-1:0] ldr_rdata;
    logic                  ldr_ready;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_write;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  cpu_cmd, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  ldr_cmd, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_ready,
        output ram_addr, ram_write, ram_din,
        input  ram_dout
    );

    modport master (
        output cpu_cmd, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output ldr_cmd, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_ready,
        input  ram_addr, ram_write, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / loader) round-robin arbiter for a 512x16 RAM with I/O decode.
// Define MEM_ARB_IO_MAP_EN to map the LED register (0x100) and switches (0x140).
module mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus,
    input  logic [7:0]     sw,
    output logic [7:0]     led,
    output logic [1:0]     owner
);
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] OWN_NONE  = 2'b00;
    localparam logic [1:0] OWN_CPU   = 2'b01;
    localparam logic [1:0] OWN_LDR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  cpu_pend_s;
    logic                  ldr_pend_s;
    logic [1:0]            grant_s;
    logic [1:0]            sel_cmd_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic [DATA_WIDTH-1:0] resp_data_s;

    logic [1:0]            owner_r;
    logic                  write_r;
    logic                  last_ldr_r;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [DATA_WIDTH-1:0] ram_din_r;
    logic                  ram_write_r;
    logic                  cpu_ready_r;
    logic                  ldr_ready_r;
    logic                  rd_ram_r;
    logic [DATA_WIDTH-1:0] io_rdata_r;

`ifdef MEM_ARB_IO_MAP_EN
    localparam logic [ADDR_WIDTH-1:0] LED_ADDR = ADDR_WIDTH'(9'h100);
    localparam logic [ADDR_WIDTH-1:0] SW_ADDR  = ADDR_WIDTH'(9'h140);

    function automatic logic [DATA_WIDTH-1:0] io_read_value(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            sw_val
    );
        if (addr == SW_ADDR) begin
            return {{(DATA_WIDTH-8){1'b0}}, sw_val};
        end else begin
            return {DATA_WIDTH{1'b0}};
        end
    endfunction
`endif

    // Pending detection: only read and write commands request the bus.
    always_comb begin
        cpu_pend_s = (bus.cpu_cmd == CMD_READ) || (bus.cpu_cmd == CMD_WRITE);
        ldr_pend_s = (bus.ldr_cmd == CMD_READ) || (bus.ldr_cmd == CMD_WRITE);
    end

    // Next-state and grant decision; on a tie the side not served last wins.
    always_comb begin
        state_s = state_r;
        grant_s = OWN_NONE;
        case (state_r)
            ST_IDLE: begin
                if (cpu_pend_s && (!ldr_pend_s || last_ldr_r)) begin
                    grant_s = OWN_CPU;
                    state_s = ST_ACCESS;
                end else if (ldr_pend_s) begin
                    grant_s = OWN_LDR;
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_s = ST_RESP;
            ST_RESP:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Mux the granted requester's command bus for latching.
    always_comb begin
        if (grant_s == OWN_LDR) begin
            sel_cmd_s   = bus.ldr_cmd;
            sel_addr_s  = bus.ldr_addr;
            sel_wdata_s = bus.ldr_wdata;
        end else begin
            sel_cmd_s   = bus.cpu_cmd;
            sel_addr_s  = bus.cpu_addr;
            sel_wdata_s = bus.cpu_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transaction latches, RAM drive and completion pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r     <= OWN_NONE;
            write_r     <= 1'b0;
            last_ldr_r  <= 1'b1;
            ram_addr_r  <= {ADDR_WIDTH{1'b0}};
            ram_din_r   <= {DATA_WIDTH{1'b0}};
            ram_write_r <= 1'b0;
            cpu_ready_r <= 1'b0;
            ldr_ready_r <= 1'b0;
            rd_ram_r    <= 1'b0;
            io_rdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            cpu_ready_r <= 1'b0;
            ldr_ready_r <= 1'b0;
            ram_write_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s != OWN_NONE) begin
                        owner_r     <= grant_s;
                        write_r     <= (sel_cmd_s == CMD_WRITE);
                        ram_addr_r  <= sel_addr_s;
                        ram_din_r   <= sel_wdata_s;
                        ram_write_r <= (sel_cmd_s == CMD_WRITE) && !sel_addr_s[ADDR_WIDTH-1];
                    end
                end
                ST_ACCESS: begin
                    last_ldr_r  <= (owner_r == OWN_LDR);
                    cpu_ready_r <= (owner_r == OWN_CPU);
                    ldr_ready_r <= (owner_r == OWN_LDR);
                    rd_ram_r    <= !write_r && !ram_addr_r[ADDR_WIDTH-1];
`ifdef MEM_ARB_IO_MAP_EN
                    io_rdata_r  <= (!write_r && ram_addr_r[ADDR_WIDTH-1])
                                   ? io_read_value(ram_addr_r, sw) : {DATA_WIDTH{1'b0}};
`else
                    io_rdata_r  <= {DATA_WIDTH{1'b0}};
`endif
                end
                ST_RESP: owner_r <= OWN_NONE;
                default: owner_r <= OWN_NONE;
            endcase
        end
    end

`ifdef MEM_ARB_IO_MAP_EN
    logic [7:0] led_r;

    // LED register loads on an I/O write to its address during ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_r <= 8'h00;
        end else if ((state_r == ST_ACCESS) && write_r && (ram_addr_r == LED_ADDR)) begin
            led_r <= ram_din_r[7:0];
        end
    end

    assign led = led_r;
`else
    logic unused_sw_s;
    assign unused_sw_s = ^sw;
    assign led         = 8'h00;
`endif

    // RAM read data arrives registered in RESP, so it is steered here, gated by ready.
    always_comb begin
        resp_data_s   = rd_ram_r ? bus.ram_dout : io_rdata_r;
        bus.cpu_rdata = cpu_ready_r ? resp_data_s : {DATA_WIDTH{1'b0}};
        bus.ldr_rdata = ldr_ready_r ? resp_data_s : {DATA_WIDTH{1'b0}};
    end

    assign bus.cpu_ready = cpu_ready_r;
    assign bus.ldr_ready = ldr_ready_r;
    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_din   = ram_din_r;
    assign bus.ram_write = ram_write_r;
    assign owner         = owner_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model
// with a behavioural registered-read RAM attached to the RAM port.
module tb_mem_arbiter;
    localparam int DW  = 16;
    localparam int AW  = 9;
    localparam int INF = 32'h3fff_ffff;
    localparam int NCYC = 1500;
`ifdef MEM_ARB_IO_MAP_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic [7:0] led;
    logic [1:0] owner;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .sw    (sw),
        .led   (led),
        .owner (owner)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read.
    logic [DW-1:0] ram_mem [0:511];
    always @(posedge clk) begin
        if (bus.ram_write) ram_mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= ram_mem[bus.ram_addr];
    end

    // Requester drive (index 0 = CPU, 1 = loader).
    logic [1:0]    a_cmd   [2];
    logic [AW-1:0] a_addr  [2];
    logic [DW-1:0] a_wdata [2];
    int            hold_until [2];

    assign bus.cpu_cmd   = a_cmd[0];
    assign bus.cpu_addr  = a_addr[0];
    assign bus.cpu_wdata = a_wdata[0];
    assign bus.ldr_cmd   = a_cmd[1];
    assign bus.ldr_addr  = a_addr[1];
    assign bus.ldr_wdata = a_wdata[1];

    // Reference model: memory image, one in-flight transaction, LED value.
    logic [DW-1:0] model_mem [0:511];
    int            cyc;
    int            free_cycle, acc_cycle, resp_cycle;
    int            txn_who, last_who;
    logic [AW-1:0] txn_addr;
    logic [DW-1:0] txn_wdata, txn_rdata;
    bit            txn_ramw;
    logic [7:0]    led_exp, led_next;
    int            led_next_cycle;
    bit            phase_b;

    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic new_request(input int a, input bit force_active);
        int            r;
        logic [AW-1:0] io_list [4];
        io_list = '{9'h100, 9'h140, 9'h1FF, 9'h120};
        r = force_active ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 9));
        if (r <= 2)      a_cmd[a] = 2'b00;
        else if (r == 3) a_cmd[a] = 2'b11;
        else if (r <= 6) a_cmd[a] = 2'b01;
        else             a_cmd[a] = 2'b10;
        if ($urandom_range(0, 3) != 0) a_addr[a] = AW'($urandom_range(0, 15));
        else                           a_addr[a] = io_list[$urandom_range(0, 3)];
        a_wdata[a] = DW'($urandom);
        hold_until[a] = (a_cmd[a] == 2'b01 || a_cmd[a] == 2'b10) ? INF : cyc + 1;
    endtask

    initial begin
        bit cpu_p, ldr_p, is_wr;
        int w;
        logic [DW-1:0] v;

        reset = 1'b1;
        sw    = 8'h00;
        for (int a = 0; a < 2; a++) begin
            a_cmd[a] = 2'b00; a_addr[a] = '0; a_wdata[a] = '0; hold_until[a] = 0;
        end
        for (int i = 0; i < 512; i++) begin
            v = DW'($urandom);
            ram_mem[i]   = v;
            model_mem[i] = v;
        end
        free_cycle = 0; acc_cycle = -1; resp_cycle = -1;
        txn_who = 0; last_who = 1; txn_ramw = 1'b0;
        txn_addr = '0; txn_wdata = '0; txn_rdata = '0;
        led_exp = 8'h00; led_next = 8'h00; led_next_cycle = -1;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            phase_b = (cyc >= 600) && (cyc < 750);
            if (led_next_cycle == cyc) led_exp = led_next;

            check_value("cpu_ready", 32'(bus.cpu_ready), 32'(resp_cycle == cyc && txn_who == 0));
            check_value("cpu_rdata", 32'(bus.cpu_rdata),
                        (resp_cycle == cyc && txn_who == 0) ? 32'(txn_rdata) : 32'h0);
            check_value("ldr_ready", 32'(bus.ldr_ready), 32'(resp_cycle == cyc && txn_who == 1));
            check_value("ldr_rdata", 32'(bus.ldr_rdata),
                        (resp_cycle == cyc && txn_who == 1) ? 32'(txn_rdata) : 32'h0);
            check_value("ram_write", 32'(bus.ram_write), 32'(acc_cycle == cyc && txn_ramw));
            check_value("owner", 32'(owner),
                        (acc_cycle == cyc || resp_cycle == cyc) ? ((txn_who == 0) ? 32'h1 : 32'h2) : 32'h0);
            check_value("led", 32'(led), 32'(led_exp));
            if (acc_cycle == cyc) begin
                check_value("ram_addr", 32'(bus.ram_addr), 32'(txn_addr));
                check_value("ram_din", 32'(bus.ram_din), 32'(txn_wdata));
            end

            reset = (cyc < 3) || (cyc >= 5 && $urandom_range(0, 59) == 0);
            if (reset) begin
                if (acc_cycle > cyc) acc_cycle = -1;
                if (resp_cycle > cyc) begin
                    resp_cycle = -1;
                    hold_until[txn_who] = cyc + 1;
                end
                last_who = 1;
                free_cycle = cyc + 1;
                led_next = 8'h00;
                led_next_cycle = cyc + 1;
            end

            for (int a = 0; a < 2; a++) begin
                if (cyc >= hold_until[a]) begin
                    if (phase_b || $urandom_range(0, 2) == 0) new_request(a, phase_b);
                    else if (a_cmd[a] == 2'b01 || a_cmd[a] == 2'b10) hold_until[a] = INF;
                end
            end

            if (cyc >= free_cycle && $urandom_range(0, 3) == 0) sw = 8'($urandom);

            if (!reset && cyc >= free_cycle) begin
                cpu_p = (a_cmd[0] == 2'b01) || (a_cmd[0] == 2'b10);
                ldr_p = (a_cmd[1] == 2'b01) || (a_cmd[1] == 2'b10);
                if (cpu_p || ldr_p) begin
                    if (cpu_p && ldr_p) w = (last_who == 0) ? 1 : 0;
                    else                w = cpu_p ? 0 : 1;
                    txn_who = w; last_who = w;
                    txn_addr = a_addr[w]; txn_wdata = a_wdata[w];
                    is_wr = (a_cmd[w] == 2'b10);
                    acc_cycle = cyc + 1; resp_cycle = cyc + 2; free_cycle = cyc + 3;
                    hold_until[w] = cyc + 3;
                    txn_ramw = is_wr && !txn_addr[8];
                    if (is_wr) begin
                        txn_rdata = 16'h0000;
                        if (!txn_addr[8]) model_mem[txn_addr] = txn_wdata;
                        else if (IO_EN && txn_addr == 9'h100) begin
                            led_next = txn_wdata[7:0];
                            led_next_cycle = cyc + 2;
                        end
                    end else begin
                        if (!txn_addr[8])                      txn_rdata = model_mem[txn_addr];
                        else if (IO_EN && txn_addr == 9'h140)  txn_rdata = {8'h00, sw};
                        else                                   txn_rdata = 16'h0000;
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
